// File: rtl/db_mv_buf.sv
// Ping-pong motion-vector buffer between the MV writer and the deblocking MV reader.
// Optional macro DB_MV_BUF_ZERO_FILL_EN adds per-entry valid bits so unwritten entries read as 0.
module db_mv_buf #(
    parameter int unsigned FMV_WIDTH  = 10,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_val_i,
    input  logic [DEPTH_LOG2-1:0]  wr_addr_i,
    input  logic [2*FMV_WIDTH-1:0] wr_dat_i,
    input  logic                   wr_done_i,
    output logic                   wr_rdy_o,
    input  logic                   mb_mv_ren_i,
    input  logic [DEPTH_LOG2-1:0]  mb_mv_raddr_i,
    output logic [2*FMV_WIDTH-1:0] mb_mv_rdata_o,
    output logic                   rd_vld_o,
    input  logic                   rd_done_i
);

    localparam int unsigned DW    = 2 * FMV_WIDTH;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          wr_rdy_q, wr_rdy_d;
    logic          rd_vld_q, rd_vld_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wr_acc, wr_hand, rd_rel;
    logic [DW-1:0] rd_word;

    assign wr_acc  = wr_val_i && wr_rdy_q;
    assign wr_hand = wr_done_i && wr_rdy_q;
    assign rd_rel  = rd_done_i && rd_vld_q;

    // Storage carries no reset; reset only discards ownership state.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (wr_bank_q) begin
                bank1[wr_addr_i] <= wr_dat_i;
            end else begin
                bank0[wr_addr_i] <= wr_dat_i;
            end
        end
    end

`ifdef DB_MV_BUF_ZERO_FILL_EN
    logic [DEPTH-1:0] valid0_q, valid0_d;
    logic [DEPTH-1:0] valid1_q, valid1_d;
    logic             rd_valid_bit;

    always_comb begin
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        if (wr_acc) begin
            if (wr_bank_q) begin
                valid1_d[wr_addr_i] = 1'b1;
            end else begin
                valid0_d[wr_addr_i] = 1'b1;
            end
        end
        if (rd_rel) begin
            if (rd_bank_q) begin
                valid1_d = '0;
            end else begin
                valid0_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_q <= '0;
            valid1_q <= '0;
        end else begin
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

    assign rd_valid_bit = rd_bank_q ? valid1_q[mb_mv_raddr_i] : valid0_q[mb_mv_raddr_i];
    assign rd_word = rd_valid_bit ?
                     (rd_bank_q ? bank1[mb_mv_raddr_i] : bank0[mb_mv_raddr_i]) : '0;
`else
    assign rd_word = rd_bank_q ? bank1[mb_mv_raddr_i] : bank0[mb_mv_raddr_i];
`endif

    // Handover and release always target different banks, so both may apply at once.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (wr_hand) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_rel) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_comb begin
        wr_rdy_d = ~full_d[wr_bank_d];
        rd_vld_d = full_d[rd_bank_d];
        rdata_d  = rdata_q;
        if (!mb_mv_ren_i) begin
            rdata_d = rd_vld_q ? rd_word : '0;
        end
    end

    // Flags are registered so every output is 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            wr_rdy_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            wr_rdy_q  <= wr_rdy_d;
            rd_vld_q  <= rd_vld_d;
            rdata_q   <= rdata_d;
        end
    end

    assign wr_rdy_o      = wr_rdy_q;
    assign rd_vld_o      = rd_vld_q;
    assign mb_mv_rdata_o = rdata_q;

endmodule

// File: tb/tb_db_mv_buf.sv
// Directed self-checking bench for db_mv_buf; zero-fill scenario runs when
// DB_MV_BUF_ZERO_FILL_EN is defined.
module tb_db_mv_buf;

    localparam int unsigned FMV_WIDTH = 10;
    localparam int unsigned DW        = 2 * FMV_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_val_i;
    logic [5:0]    wr_addr_i;
    logic [DW-1:0] wr_dat_i;
    logic          wr_done_i;
    logic          wr_rdy_o;
    logic          mb_mv_ren_i;
    logic [5:0]    mb_mv_raddr_i;
    logic [DW-1:0] mb_mv_rdata_o;
    logic          rd_vld_o;
    logic          rd_done_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    db_mv_buf #(.FMV_WIDTH(FMV_WIDTH), .DEPTH_LOG2(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_val_i      (wr_val_i),
        .wr_addr_i     (wr_addr_i),
        .wr_dat_i      (wr_dat_i),
        .wr_done_i     (wr_done_i),
        .wr_rdy_o      (wr_rdy_o),
        .mb_mv_ren_i   (mb_mv_ren_i),
        .mb_mv_raddr_i (mb_mv_raddr_i),
        .mb_mv_rdata_o (mb_mv_rdata_o),
        .rd_vld_o      (rd_vld_o),
        .rd_done_i     (rd_done_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_bank(input int base, input int step);
        for (int i = 0; i < 64; i++) begin
            wr_val_i  = 1'b1;
            wr_addr_i = 6'(i);
            wr_dat_i  = DW'(base + i * step);
            tick();
        end
        wr_val_i = 1'b0;
    endtask

    task automatic write_one(input int addr, input int dat);
        wr_val_i  = 1'b1;
        wr_addr_i = 6'(addr);
        wr_dat_i  = DW'(dat);
        tick();
        wr_val_i  = 1'b0;
    endtask

    task automatic pulse_wr_done();
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
    endtask

    task automatic pulse_rd_done();
        rd_done_i = 1'b1;
        tick();
        rd_done_i = 1'b0;
    endtask

    task automatic read_one(input int addr, output logic [DW-1:0] d);
        mb_mv_ren_i   = 1'b0;
        mb_mv_raddr_i = 6'(addr);
        tick();
        mb_mv_ren_i   = 1'b1;
        d = mb_mv_rdata_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({wr_rdy_o, rd_vld_o, mb_mv_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h, want all 0",
                     wr_rdy_o, rd_vld_o, mb_mv_rdata_o);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (wr_rdy_o !== 1'b1 || rd_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got rdy=%b vld=%b, want rdy=1 vld=0", wr_rdy_o, rd_vld_o);
        end
    endtask

    task automatic test_fill_read();
        int bad = 0;
        fill_bank(0, 3);
        pulse_wr_done();
        checks++;
        if (rd_vld_o !== 1'b1 || wr_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL handover_flags: got vld=%b rdy=%b, want vld=1 rdy=1", rd_vld_o, wr_rdy_o);
        end
        for (int i = 0; i < 64; i++) begin
            mb_mv_ren_i   = 1'b0;
            mb_mv_raddr_i = 6'(i);
            tick();
            checks++;
            if (mb_mv_rdata_o !== DW'(i * 3)) begin
                errors++;
                $display("FAIL read_addr%0d: got %h, want %h", i, mb_mv_rdata_o, DW'(i * 3));
            end
        end
        mb_mv_ren_i = 1'b1;
        pulse_rd_done();
        checks++;
        if (rd_vld_o !== 1'b0 || wr_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL release_flags: got vld=%b rdy=%b, want vld=0 rdy=1", rd_vld_o, wr_rdy_o);
        end
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] d;
        fill_bank('h11, 0);
        pulse_wr_done();
        fill_bank('h22, 0);
        pulse_wr_done();
        checks++;
        if (wr_rdy_o !== 1'b0 || rd_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL both_full: got rdy=%b vld=%b, want rdy=0 vld=1", wr_rdy_o, rd_vld_o);
        end
        write_one(5, 'h3FF);
        read_one(5, d);
        checks++;
        if (d !== DW'('h11)) begin
            errors++;
            $display("FAIL stall_read: got %h, want 11", d);
        end
        rd_done_i = 1'b1;
        checks++;
        if (wr_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL rdy_not_comb: got rdy=%b, want 0", wr_rdy_o);
        end
        tick();
        rd_done_i = 1'b0;
        checks++;
        if (wr_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_release: got rdy=%b, want 1", wr_rdy_o);
        end
        read_one(5, d);
        checks++;
        if (d !== DW'('h22)) begin
            errors++;
            $display("FAIL dropped_write: got %h, want 22", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d;
        fill_bank('h33, 0);
        wr_done_i     = 1'b1;
        rd_done_i     = 1'b1;
        mb_mv_ren_i   = 1'b0;
        mb_mv_raddr_i = 6'd3;
        tick();
        wr_done_i   = 1'b0;
        rd_done_i   = 1'b0;
        mb_mv_ren_i = 1'b1;
        checks++;
        if (mb_mv_rdata_o !== DW'('h22)) begin
            errors++;
            $display("FAIL read_during_release: got %h, want 22", mb_mv_rdata_o);
        end
        checks++;
        if (rd_vld_o !== 1'b1 || wr_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_flags: got vld=%b rdy=%b, want vld=1 rdy=1", rd_vld_o, wr_rdy_o);
        end
        read_one(9, d);
        checks++;
        if (d !== DW'('h33)) begin
            errors++;
            $display("FAIL simul_read: got %h, want 33", d);
        end
        pulse_rd_done();
    endtask

    task automatic test_hold();
        logic [DW-1:0] d;
        fill_bank('h40, 1);
        pulse_wr_done();
        read_one('h1A, d);
        mb_mv_raddr_i = 6'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (mb_mv_rdata_o !== DW'('h5A)) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h, want 5a", i, mb_mv_rdata_o);
            end
        end
        pulse_rd_done();
    endtask

    task automatic test_not_valid();
        logic [DW-1:0] d;
        read_one(3, d);
        checks++;
        if (d !== '0) begin
            errors++;
            $display("FAIL read_not_valid: got %h, want 0", d);
        end
        pulse_rd_done();
        checks++;
        if (rd_vld_o !== 1'b0 || wr_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_rd_done: got vld=%b rdy=%b, want vld=0 rdy=1", rd_vld_o, wr_rdy_o);
        end
        fill_bank('h77, 0);
        pulse_wr_done();
        checks++;
        if (rd_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_rd_done_bank: got vld=%b, want 1", rd_vld_o);
        end
        read_one(0, d);
        checks++;
        if (d !== DW'('h77)) begin
            errors++;
            $display("FAIL idle_rd_done_data: got %h, want 77", d);
        end
        pulse_rd_done();
    endtask

`ifdef DB_MV_BUF_ZERO_FILL_EN
    task automatic test_zero_fill();
        logic [DW-1:0] d;
        write_one(7, 'h123);
        pulse_wr_done();
        read_one(6, d);
        checks++;
        if (d !== '0) begin
            errors++;
            $display("FAIL zf_unwritten: got %h, want 0", d);
        end
        read_one(7, d);
        checks++;
        if (d !== DW'('h123)) begin
            errors++;
            $display("FAIL zf_written: got %h, want 123", d);
        end
        pulse_rd_done();
        write_one(6, 'h55);
        pulse_wr_done();
        read_one(7, d);
        checks++;
        if (d !== '0) begin
            errors++;
            $display("FAIL zf_stale: got %h, want 0", d);
        end
        read_one(6, d);
        checks++;
        if (d !== DW'('h55)) begin
            errors++;
            $display("FAIL zf_refill: got %h, want 55", d);
        end
        pulse_rd_done();
    endtask
`endif

    task automatic test_reset_mid_fill();
        logic [DW-1:0] d;
        fill_bank('h99, 0);
        pulse_wr_done();
        read_one(1, d);
        for (int i = 0; i < 5; i++) begin
            write_one(i, 'h1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_rdy_o, rd_vld_o, mb_mv_rdata_o} !== '0) begin
            errors++;
            $display("FAIL midfill_reset: got rdy=%b vld=%b rdata=%h, want all 0",
                     wr_rdy_o, rd_vld_o, mb_mv_rdata_o);
        end
        #4;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (wr_rdy_o !== 1'b1 || rd_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b vld=%b, want rdy=1 vld=0", wr_rdy_o, rd_vld_o);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        wr_val_i      = 1'b0;
        wr_addr_i     = '0;
        wr_dat_i      = '0;
        wr_done_i     = 1'b0;
        mb_mv_ren_i   = 1'b1;
        mb_mv_raddr_i = '0;
        rd_done_i     = 1'b0;
        #12;
        test_reset();
        test_fill_read();
        test_full_stall();
        test_simultaneous();
        test_hold();
        test_not_valid();
`ifdef DB_MV_BUF_ZERO_FILL_EN
        test_zero_fill();
`endif
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/db_mv_buf.md
Name: db_mv_buf

Overview:
- Ping-pong motion-vector store between the inter-prediction/MV writer and the deblocking MV reader.
- The writer fills one 64-entry bank: one MV pair per 8x8 block of a 64x64 CTU.
- While that bank fills, the deblocking side reads the other bank through the mb_mv read port: low-active read enable, 6-bit address, 1-cycle read latency.
- Bank ownership is handed over with done pulses, so the writer can fill CTU n+1 while deblocking processes CTU n.

Parameters:
- FMV_WIDTH, 10, width of one MV component; an entry is {mv_x, mv_y}, 2*FMV_WIDTH bits.
- DEPTH_LOG2, 6, log2 of entries per bank; fixed at 6 (64 entries) for a 64x64 CTU.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_val_i  in  1  write strobe, active high
- wr_addr_i  in  6  write entry index {y8[2:0], x8[2:0]}
- wr_dat_i  in  2*FMV_WIDTH  MV pair to store
- wr_done_i  in  1  pulse: current CTU fully written, hand the bank to the reader
- wr_rdy_o  out  1  the write bank is free and writes are accepted
- mb_mv_ren_i  in  1  read enable, active low
- mb_mv_raddr_i  in  6  read entry index
- mb_mv_rdata_o  out  2*FMV_WIDTH  read data, one cycle after ren low
- rd_vld_o  out  1  a full bank is available to the reader
- rd_done_i  in  1  pulse: reader finished the CTU, release its bank

Behaviour:
- Reset value of every output: 0.
- Reset value of internal state: wr_bank=0, rd_bank=0, full[1:0]=0, and valid bits 0 when the optional feature is compiled in.
- Reset is asynchronous and takes effect mid-CTU; all in-flight data is discarded.
- Storage: two banks of 64 x 2*FMV_WIDTH, either registers or two single-port RAMs.
- Output flags: wr_rdy_o = !full[wr_bank]; rd_vld_o = full[rd_bank].
- Write: when wr_val_i && wr_rdy_o, bank[wr_bank][wr_addr_i] <= wr_dat_i.
  - When wr_rdy_o=0, writes are dropped silently and no stored data changes.
  - Rewriting the same address before wr_done_i: the last write wins.
- Write handover: when wr_done_i && wr_rdy_o, full[wr_bank] <= 1 and wr_bank toggles.
  - A write in the same cycle lands in the old bank before the toggle.
  - wr_done_i while wr_rdy_o=0 is ignored.
- Read: when mb_mv_ren_i==0, mb_mv_rdata_o <= bank[rd_bank][mb_mv_raddr_i] on the next edge (latency 1).
  - When mb_mv_ren_i==1, mb_mv_rdata_o holds its value.
  - Reads while rd_vld_o=0 return 0 on the next cycle.
- Read release: when rd_done_i && rd_vld_o, full[rd_bank] <= 0 and rd_bank toggles.
  - rd_done_i while rd_vld_o=0 is ignored.
  - A read enabled in the same cycle as rd_done_i still returns data from the old bank.
- Simultaneous wr_done_i and rd_done_i: both take effect in the same cycle.
  - If the writer was stalled on the bank being released, wr_rdy_o rises on the following cycle, not combinationally.
- Both banks full: wr_rdy_o=0 until rd_done_i.
- Both banks empty: rd_vld_o=0 until wr_done_i.
- By construction, read and write never target the same valid bank, so no RAM collision logic is required.

Optional Feature:
- Macro: DB_MV_BUF_ZERO_FILL_EN.
- Defined:
  - Each bank keeps a 64-bit valid vector.
  - An accepted write sets valid[wr_bank][wr_addr_i].
  - rd_done_i release clears the entire valid vector of the released bank.
  - A read of an entry with valid=0 returns 0, for intra or unwritten blocks.
  - The writer may therefore write only inter blocks.
- Undefined:
  - No valid vectors exist.
  - Unwritten entries return stale bank contents.
  - The writer must write all 64 entries per CTU.

Test Plan:
- Reset, write 64 entries with dat=addr*3, pulse wr_done, then read addr 0..63 with ren low -> rd_vld_o=1 one cycle after wr_done; each rdata equals addr*3 one cycle after its address; wr_rdy_o stays 1 because bank 1 is free.
- Fill bank 0 (dat=0x11), hand over, fill bank 1 (dat=0x22), hand over, then write addr 5 = 0x3FF -> wr_rdy_o=0; the 0x3FF write is dropped; reading addr 5 returns 0x11.
- Then pulse rd_done and read addr 5 -> rd_bank toggles, read returns 0x22, wr_rdy_o returns to 1 the next cycle.
- Hold ren high for 4 cycles after a read of value 0x5A -> rdata stays 0x5A.
- Read with rd_vld_o=0 -> rdata=0; rd_done with rd_vld_o=0 -> no state change.
- Assert wr_done and rd_done in the same cycle while bank 0 is full and bank 1 is filling -> full becomes {1,0}, wr_bank=0, rd_bank=1.
- With DB_MV_BUF_ZERO_FILL_EN, write only addr 7 = 0x123, hand over, read addr 6 and 7 -> 0 and 0x123.
  - Release, refill writing only addr 6, hand over again, read addr 7 -> 0.
- Assert rst_n low mid-fill -> all outputs 0 asynchronously; after release, wr_rdy_o=1 and rd_vld_o=0.
